// File: rtl/strobe_sched_ctrl_if.sv
// Channel-side bundle for strobe_sched_ctrl: config handshake, user word
// handshake with marker, and the strobe generator's online/interval/strobe.
// master = the controller, slave = the surrounding datapath/generator.
interface strobe_sched_ctrl_if #(
  parameter int MP_W = 8
);
  logic            cfg_valid;
  logic            cfg_ready;
  logic [15:0]     cfg_interval;
  logic [MP_W-1:0] cfg_period;
  logic            word_valid;
  logic            word_ready;
  logic            user_marker;
  logic            online;
  logic [15:0]     interval;
  logic            user_strobe;

  modport master (
    input  cfg_valid, cfg_interval, cfg_period, word_valid, user_strobe,
    output cfg_ready, word_ready, user_marker, online, interval
  );

  modport slave (
    output cfg_valid, cfg_interval, cfg_period, word_valid, user_strobe,
    input  cfg_ready, word_ready, user_marker, online, interval
  );
endinterface

// File: rtl/strobe_sched_ctrl.sv
// Strobe/marker sequencing controller for an AIB user channel.
// Brings the channel online after link-up plus a settle delay, gates the user
// word handshake, tags the last word of each marker period, and applies new
// interval/period settings only at a period boundary behind a short offline gap.
// Optional strobe watchdog: define STROBE_SCHED_CHECK_EN to build it.
module strobe_sched_ctrl #(
  parameter int MP_W          = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int RECFG_GAP     = 2,
  parameter int WDOG_SLACK    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                link_ready,
  strobe_sched_ctrl_if.master bus,
  output logic [1:0]          state,
  output logic                strobe_err
);

  typedef enum logic [1:0] {
    ST_OFFLINE = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_RUN     = 2'd2,
    ST_GAP     = 2'd3
  } state_t;

  // One shared down-counter times both SETTLE and GAP.
  localparam int TMR_MAX = (SETTLE_CYCLES > RECFG_GAP) ? SETTLE_CYCLES : RECFG_GAP;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LD    = TMR_W'(RECFG_GAP - 1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [MP_W-1:0]  CNT_ONE   = MP_W'(1);

  state_t          st_q;
  logic [TMR_W-1:0] tmr_q;
  logic [15:0]     interval_q;
  logic [MP_W-1:0] period_q;
  logic [MP_W-1:0] cnt_q;
  logic            pend_q;
  logic [15:0]     pend_interval_q;
  logic [MP_W-1:0] pend_period_q;

  logic            drop;
  logic            hs;
  logic            cfg_fire;
  logic            at_end;
  logic            gap_go;
  logic [MP_W-1:0] eff_m1;

  assign drop     = !enable || !link_ready;
  assign hs       = bus.word_valid && bus.word_ready;
  assign cfg_fire = bus.cfg_valid && !pend_q;
  // A period of 0 behaves as 1, so the last-word index is 0 in both cases.
  assign eff_m1   = (period_q == '0) ? '0 : (period_q - CNT_ONE);
  assign at_end   = (cnt_q == eff_m1);
  assign gap_go   = (st_q == ST_RUN) && pend_q && (cnt_q == '0) && !hs;

  assign state           = st_q;
  assign bus.online      = (st_q == ST_RUN);
  assign bus.word_ready  = (st_q == ST_RUN);
  assign bus.cfg_ready   = !pend_q;
  assign bus.user_marker = hs && at_end;
  assign bus.interval    = interval_q;

  // Channel FSM plus applied/pending configuration; a link drop overrides every transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= ST_OFFLINE;
      tmr_q      <= '0;
      interval_q <= 16'h0;
      period_q   <= CNT_ONE;
      pend_q     <= 1'b0;
    end else if (drop) begin
      st_q <= ST_OFFLINE;
      if (pend_q) begin
        interval_q <= pend_interval_q;
        period_q   <= pend_period_q;
        pend_q     <= 1'b0;
      end else if (cfg_fire) begin
        interval_q <= bus.cfg_interval;
        period_q   <= bus.cfg_period;
      end
    end else begin
      case (st_q)
        ST_OFFLINE: begin
          st_q  <= ST_SETTLE;
          tmr_q <= SETTLE_LD;
        end
        ST_SETTLE: begin
          if (tmr_q == '0) st_q <= ST_RUN;
          else             tmr_q <= tmr_q - TMR_ONE;
        end
        ST_RUN: begin
          if (gap_go) begin
            st_q       <= ST_GAP;
            tmr_q      <= GAP_LD;
            interval_q <= pend_interval_q;
            period_q   <= pend_period_q;
            pend_q     <= 1'b0;
          end
        end
        ST_GAP: begin
          if (tmr_q == '0) st_q <= ST_RUN;
          else             tmr_q <= tmr_q - TMR_ONE;
        end
        default: st_q <= ST_OFFLINE;
      endcase
      // While the generator is not running a new config can land directly;
      // otherwise it waits for the next period boundary. gap_go implies
      // pend_q, so cfg_fire and GAP entry never collide on pend_q.
      if (cfg_fire) begin
        if (st_q == ST_OFFLINE || st_q == ST_SETTLE) begin
          interval_q <= bus.cfg_interval;
          period_q   <= bus.cfg_period;
        end else begin
          pend_q <= 1'b1;
        end
      end
    end
  end

  // Capture of the offered config; only meaningful while pend_q is set.
  always_ff @(posedge clk) begin
    if (cfg_fire) begin
      pend_interval_q <= bus.cfg_interval;
      pend_period_q   <= bus.cfg_period;
    end
  end

  // Accepted-word counter within the marker period; cleared by a link drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt_q <= '0;
    else if (drop)   cnt_q <= '0;
    else if (hs)     cnt_q <= at_end ? '0 : (cnt_q + CNT_ONE);
  end

`ifdef STROBE_SCHED_CHECK_EN
  logic        wd_armed_q;
  logic [16:0] wd_cnt_q;
  logic        err_q;
  logic [16:0] wd_load;

  assign wd_load    = {1'b0, interval_q} + 17'(WDOG_SLACK) + 17'd1;
  assign strobe_err = err_q;

  // Strobe watchdog: armed by a marker, disarmed by a strobe or leaving RUN; expiry or an offline strobe is a sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_armed_q <= 1'b0;
      wd_cnt_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      if (st_q != ST_RUN) begin
        wd_armed_q <= 1'b0;
      end else if (wd_armed_q) begin
        if (bus.user_strobe) begin
          wd_armed_q <= 1'b0;
        end else if (wd_cnt_q <= 17'd1) begin
          wd_armed_q <= 1'b0;
          wd_cnt_q   <= '0;
          err_q      <= 1'b1;
        end else begin
          wd_cnt_q <= wd_cnt_q - 17'd1;
        end
      end else if (bus.user_marker) begin
        wd_armed_q <= 1'b1;
        wd_cnt_q   <= wd_load;
      end
      if (bus.user_strobe && (st_q != ST_RUN)) err_q <= 1'b1;
    end
  end
`else
  logic unused_strobe;
  assign unused_strobe = bus.user_strobe;
  assign strobe_err    = 1'b0;
`endif

endmodule

// File: tb/tb_strobe_sched_ctrl.sv
// Self-checking bench for strobe_sched_ctrl: direct checks on control outputs,
// plus a marker scoreboard filled when words are driven and drained whenever
// the controller accepts a word.
module tb_strobe_sched_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       link_ready;
  logic [1:0] state;
  logic       strobe_err;

  int total = 0;
  int bad   = 0;
  bit sb_q[$];
  bit mexp;

  strobe_sched_ctrl_if #(.MP_W(8)) bus ();

  strobe_sched_ctrl #(
    .MP_W(8), .SETTLE_CYCLES(4), .RECFG_GAP(2), .WDOG_SLACK(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .link_ready(link_ready),
    .bus(bus), .state(state), .strobe_err(strobe_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input bit exp_mk);
    sb_q.push_back(exp_mk);
    bus.word_valid = 1'b1;
    tick();
    bus.word_valid = 1'b0;
  endtask

  task automatic wait_run(input int max_cyc);
    int n = 0;
    while (state !== 2'd2 && n < max_cyc) begin
      tick();
      n++;
    end
    chk("wait_run", {30'b0, state}, 32'd2);
  endtask

  task automatic offer_cfg(input logic [15:0] iv, input logic [7:0] pd);
    bus.cfg_valid    = 1'b1;
    bus.cfg_interval = iv;
    bus.cfg_period   = pd;
  endtask

  // Marker scoreboard: every accepted word must match the next expected marker.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("mk_gate", {31'b0, bus.user_marker & ~bus.word_ready}, 32'd0);
      if (bus.word_valid && bus.word_ready) begin
        chk("sb_avail", {31'b0, sb_q.size() != 0}, 32'd1);
        if (sb_q.size() != 0) begin
          mexp = sb_q.pop_front();
          chk("marker", {31'b0, bus.user_marker}, {31'b0, mexp});
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; link_ready = 1'b0;
    bus.cfg_valid = 1'b0; bus.cfg_interval = '0; bus.cfg_period = '0;
    bus.word_valid = 1'b0; bus.user_strobe = 1'b0;
    tick(); tick();

    // reset state
    chk("rst_state", {30'b0, state}, 0);
    chk("rst_online", {31'b0, bus.online}, 0);
    chk("rst_wready", {31'b0, bus.word_ready}, 0);
    chk("rst_cready", {31'b0, bus.cfg_ready}, 1);
    chk("rst_interval", {16'b0, bus.interval}, 0);
    chk("rst_err", {31'b0, strobe_err}, 0);

    // bring-up: cycle 0 enables, SETTLE cycles 1-4, RUN at 5
    rst_n = 1'b1; enable = 1'b1; link_ready = 1'b1;
    bus.word_valid = 1'b1;
    chk("bu_wready0", {31'b0, bus.word_ready}, 0);
    tick();
    for (int c = 1; c <= 4; c++) begin
      chk("bu_settle", {30'b0, state}, 1);
      chk("bu_wready", {31'b0, bus.word_ready}, 0);
      if (c == 2) offer_cfg(16'd5, 8'd3);
      if (c == 3) begin
        chk("settle_cfg_iv", {16'b0, bus.interval}, 5);
        chk("settle_cfg_rdy", {31'b0, bus.cfg_ready}, 1);
      end
      tick();
      bus.cfg_valid = 1'b0;
    end
    bus.word_valid = 1'b0;
    chk("bu_run", {30'b0, state}, 2);
    chk("bu_online", {31'b0, bus.online}, 1);

    // period 3: markers on words 3, 6, 9
    for (int i = 0; i < 9; i++) send_word(i % 3 == 2);

    // reconfig in RUN after word 1 of 3
    send_word(1'b0);
    offer_cfg(16'd9, 8'd0);
    send_word(1'b0);
    bus.cfg_valid = 1'b0;
    chk("rc_cready0", {31'b0, bus.cfg_ready}, 0);
    send_word(1'b1);
    chk("rc_no_early_gap", {30'b0, state}, 2);
    chk("rc_iv_old", {16'b0, bus.interval}, 5);
    tick();
    chk("rc_gap", {30'b0, state}, 3);
    chk("rc_gap_online", {31'b0, bus.online}, 0);
    chk("rc_gap_wready", {31'b0, bus.word_ready}, 0);
    chk("rc_iv_new", {16'b0, bus.interval}, 9);
    chk("rc_cready1", {31'b0, bus.cfg_ready}, 1);
    tick();
    chk("rc_gap2", {30'b0, state}, 3);
    tick();
    chk("rc_back_run", {30'b0, state}, 2);

    // period 0: marker on every word
    for (int i = 0; i < 4; i++) send_word(1'b1);

    // period 4, then link drop after 2 words
    offer_cfg(16'd9, 8'd4);
    tick();
    bus.cfg_valid = 1'b0;
    tick();
    chk("p4_gap", {30'b0, state}, 3);
    wait_run(10);
    send_word(1'b0);
    send_word(1'b0);
    link_ready = 1'b0;
    tick();
    chk("drop_state", {30'b0, state}, 0);
    chk("drop_online", {31'b0, bus.online}, 0);
    link_ready = 1'b1;
    wait_run(20);
    for (int i = 0; i < 4; i++) send_word(i == 3);

    // link drop in the cycle GAP would be entered
    offer_cfg(16'd33, 8'd2);
    tick();
    bus.cfg_valid = 1'b0;
    chk("sim_cready0", {31'b0, bus.cfg_ready}, 0);
    chk("sim_run", {30'b0, state}, 2);
    link_ready = 1'b0;
    tick();
    chk("sim_offline", {30'b0, state}, 0);
    chk("sim_iv", {16'b0, bus.interval}, 33);
    chk("sim_cready1", {31'b0, bus.cfg_ready}, 1);
    link_ready = 1'b1;
    wait_run(20);
    tick();
    chk("sim_no_gap", {30'b0, state}, 2);
    for (int i = 0; i < 4; i++) send_word(i % 2 == 1);

    // config offered in the last SETTLE cycle
    link_ready = 1'b0;
    tick();
    link_ready = 1'b1;
    tick();
    repeat (3) tick();
    chk("sc_settle_last", {30'b0, state}, 1);
    offer_cfg(16'd77, 8'd1);
    tick();
    bus.cfg_valid = 1'b0;
    chk("sc_run", {30'b0, state}, 2);
    chk("sc_iv", {16'b0, bus.interval}, 77);
    chk("sc_cready", {31'b0, bus.cfg_ready}, 1);
    tick();
    chk("sc_no_gap", {30'b0, state}, 2);
    for (int i = 0; i < 3; i++) send_word(1'b1);

`ifdef STROBE_SCHED_CHECK_EN
    // strobe 5 cycles after the marker keeps the watchdog quiet
    link_ready = 1'b0;
    tick();
    offer_cfg(16'd5, 8'd1);
    tick();
    bus.cfg_valid = 1'b0;
    link_ready = 1'b1;
    wait_run(20);
    send_word(1'b1);
    repeat (4) tick();
    bus.user_strobe = 1'b1;
    tick();
    bus.user_strobe = 1'b0;
    repeat (10) tick();
    chk("wd_ok", {31'b0, strobe_err}, 0);
`endif

    // strobe while offline
    link_ready = 1'b0;
    tick();
    bus.user_strobe = 1'b1;
    tick();
    bus.user_strobe = 1'b0;
    tick();
`ifdef STROBE_SCHED_CHECK_EN
    chk("off_strobe_err", {31'b0, strobe_err}, 1);

    // missing strobe: error 10 cycles after the marker, sticky
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; link_ready = 1'b1;
    offer_cfg(16'd5, 8'd1);
    tick();
    bus.cfg_valid = 1'b0;
    chk("wd_rst_err", {31'b0, strobe_err}, 0);
    wait_run(20);
    send_word(1'b1);
    repeat (8) tick();
    chk("wd_pre", {31'b0, strobe_err}, 0);
    repeat (2) tick();
    chk("wd_fire", {31'b0, strobe_err}, 1);
    repeat (9) tick();
    chk("wd_sticky", {31'b0, strobe_err}, 1);
`else
    chk("off_strobe_err", {31'b0, strobe_err}, 0);
`endif

    tick();
    chk("sb_left", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
